// File: rtl/mfp_ahb_arbiter.sv
// Two-master AHB-Lite arbiter: registered grants, address/data muxes,
// round-robin with a hold limit, never splitting bursts or locked runs.
module mfp_ahb_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_HOLD = 8
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              M0_HBUSREQ,
  input  logic              M0_HMASTLOCK,
  input  logic [1:0]        M0_HTRANS,
  input  logic [ADDR_W-1:0] M0_HADDR,
  input  logic              M0_HWRITE,
  input  logic [2:0]        M0_HSIZE,
  input  logic [2:0]        M0_HBURST,
  input  logic [3:0]        M0_HPROT,
  input  logic [DATA_W-1:0] M0_HWDATA,
  output logic              M0_HGRANT,
  input  logic              M1_HBUSREQ,
  input  logic              M1_HMASTLOCK,
  input  logic [1:0]        M1_HTRANS,
  input  logic [ADDR_W-1:0] M1_HADDR,
  input  logic              M1_HWRITE,
  input  logic [2:0]        M1_HSIZE,
  input  logic [2:0]        M1_HBURST,
  input  logic [3:0]        M1_HPROT,
  input  logic [DATA_W-1:0] M1_HWDATA,
  output logic              M1_HGRANT,
  input  logic              HREADY,
  output logic [1:0]        HTRANS,
  output logic [ADDR_W-1:0] HADDR,
  output logic              HWRITE,
  output logic [2:0]        HSIZE,
  output logic [2:0]        HBURST,
  output logic [3:0]        HPROT,
  output logic              HMASTLOCK,
  output logic [DATA_W-1:0] HWDATA,
  output logic              HMASTER
);

  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);
  localparam logic [1:0] SEQ = 2'b11;

  logic [1:0]    gnt_q, gnt_d;
  logic          addr_own_q, addr_own_d;
  logic          data_own_q, data_own_d;
  logic          last_q, last_d;
  logic [HW-1:0] hold_q, hold_d;

  logic [1:0] req;
  logic [1:0] own_trans;
  logic       own_lock;
  logic       own_req;
  logic       other_req;
  logic       busy;
  logic       gidx;
  logic       nxt;

  assign req  = {M1_HBUSREQ, M0_HBUSREQ};
  assign gidx = gnt_q[1];

  always_comb begin
    own_trans = addr_own_q ? M1_HTRANS : M0_HTRANS;
    own_lock  = addr_own_q ? M1_HMASTLOCK : M0_HMASTLOCK;
    own_req   = req[addr_own_q];
    other_req = req[~addr_own_q];
    busy      = (own_trans == SEQ) || own_lock;

    // single requester wins; nobody requesting parks on M0
    nxt = req[1];
    if (busy) begin
      nxt = gidx;
    end else if (&req) begin
      if (hold_q >= HOLD_MAX) begin
        nxt = ~addr_own_q;
      end else begin
        nxt = own_req ? gidx : ~last_q;
      end
    end

    gnt_d      = gnt_q;
    addr_own_d = addr_own_q;
    data_own_d = data_own_q;
    last_d     = last_q;
    hold_d     = hold_q;

    if (HREADY) begin
      gnt_d      = nxt ? 2'b10 : 2'b01;
      addr_own_d = gidx;
      data_own_d = addr_own_q;
      if (nxt != gidx) begin
        last_d = nxt;
      end
    end

    if (!other_req) begin
      hold_d = '0;
    end else if (HREADY) begin
      if (nxt != gidx) begin
        hold_d = '0;
      end else if (own_trans[1] && hold_q < HOLD_MAX) begin
        hold_d = hold_q + 1'b1;
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      gnt_q      <= 2'b01;
      addr_own_q <= 1'b0;
      data_own_q <= 1'b0;
      last_q     <= 1'b1;
      hold_q     <= '0;
    end else begin
      gnt_q      <= gnt_d;
      addr_own_q <= addr_own_d;
      data_own_q <= data_own_d;
      last_q     <= last_d;
      hold_q     <= hold_d;
    end
  end

  assign M0_HGRANT = gnt_q[0];
  assign M1_HGRANT = gnt_q[1];
  assign HMASTER   = addr_own_q;

  assign HTRANS    = addr_own_q ? M1_HTRANS    : M0_HTRANS;
  assign HADDR     = addr_own_q ? M1_HADDR     : M0_HADDR;
  assign HWRITE    = addr_own_q ? M1_HWRITE    : M0_HWRITE;
  assign HSIZE     = addr_own_q ? M1_HSIZE     : M0_HSIZE;
  assign HBURST    = addr_own_q ? M1_HBURST    : M0_HBURST;
  assign HPROT     = addr_own_q ? M1_HPROT     : M0_HPROT;
  assign HMASTLOCK = addr_own_q ? M1_HMASTLOCK : M0_HMASTLOCK;
  assign HWDATA    = data_own_q ? M1_HWDATA    : M0_HWDATA;

endmodule
